// File: rtl/adam_rst_pkg.sv
// rtl/adam_rst_pkg.sv - shared types and helpers for the board reset sequencer
package adam_rst_pkg;

  typedef enum logic [1:0] {
    RC_POR         = 2'd0,
    RC_BTN         = 2'd1,
    RC_BTN_TIMEOUT = 2'd2
  } rst_cause_t;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    PAUSE
  } rst_state_t;

  // Counter width able to hold param-1 with a spare bit; never below 2 bits.
  function automatic int cnt_width(input int p);
    return $clog2((p < 2) ? 2 : p) + 1;
  endfunction

endpackage

// File: rtl/adam_debounce.sv
// rtl/adam_debounce.sv - pushbutton synchroniser plus stable-level debouncer
module adam_debounce
  import adam_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      out    <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      // Any cycle of agreement restarts the stability window.
      if (synced != out) begin
        if (cnt_q == CNT_LAST) begin
          out   <= synced;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/adam_rst_seq.sv
// rtl/adam_rst_seq.sv - board reset sequencer: POR/button hold, pause handshake, cause tracking
module adam_rst_seq
  import adam_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 16,
  parameter int PAUSE_TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_rst_n,
  input  logic       pause_ack,
  output logic       pause_req,
  output logic       rst_out,
  output logic [1:0] rst_cause
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int TW = cnt_width(PAUSE_TIMEOUT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'((PAUSE_TIMEOUT > 0) ? PAUSE_TIMEOUT - 1 : 0);

  rst_state_t    state_q, state_d;
  rst_cause_t    cause_q, cause_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rst_out_d, pause_req_d;
  logic          btn_db;

  adam_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk(clk),
    .rst(rst),
    .in (btn_rst_n),
    .out(btn_db)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HOLD;
      cause_q    <= RC_POR;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
      rst_out    <= 1'b1;
      pause_req  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
      rst_out    <= rst_out_d;
      pause_req  <= pause_req_d;
    end
  end

  assign rst_cause = cause_q;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    hold_cnt_d  = hold_cnt_q;
    to_cnt_d    = to_cnt_q;
    rst_out_d   = rst_out;
    pause_req_d = pause_req;
    case (state_q)
      HOLD: begin
        rst_out_d   = 1'b1;
        pause_req_d = 1'b0;
        // The hold stretch only starts counting once the button is released.
        if (!btn_db) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = RUN;
          rst_out_d  = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        rst_out_d = 1'b0;
        if (!btn_db) begin
          if (PAUSE_TIMEOUT == 0) begin
            state_d    = HOLD;
            rst_out_d  = 1'b1;
            cause_d    = RC_BTN;
            hold_cnt_d = '0;
          end else begin
            state_d     = PAUSE;
            pause_req_d = 1'b1;
            to_cnt_d    = '0;
          end
        end
      end
      PAUSE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // Ack is checked first so it wins over a coincident timeout.
        if (pause_ack || (to_cnt_q == TO_LAST)) begin
          state_d     = HOLD;
          rst_out_d   = 1'b1;
          pause_req_d = 1'b0;
          cause_d     = pause_ack ? RC_BTN : RC_BTN_TIMEOUT;
          hold_cnt_d  = '0;
          to_cnt_d    = '0;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_adam_rst_seq.sv
// tb/tb_adam_rst_seq.sv - scoreboard bench for adam_rst_seq output change events
module tb_adam_rst_seq;

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       btn_rst_n;
  logic       pause_ack;
  logic       pause_req;
  logic       rst_out;
  logic [1:0] rst_cause;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  logic [3:0] mon_prev = 4'bxxxx;
  logic [3:0] mon_cur;
  exp_t       mon_e;

  adam_rst_seq dut (
    .clk      (clk),
    .rst      (rst),
    .btn_rst_n(btn_rst_n),
    .pause_ack(pause_ack),
    .pause_req(pause_req),
    .rst_out  (rst_out),
    .rst_cause(rst_cause)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event vector is {rst_out, pause_req, rst_cause}; cycle = posedge count that produced it.
  task automatic push(input int c, input logic ro, input logic pr, input logic [1:0] rc);
    exp_t e;
    e.cyc = c;
    e.v   = {ro, pr, rc};
    exp_q.push_back(e);
  endtask

  task automatic at(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      mon_cur = {rst_out, pause_req, rst_cause};
      if (mon_cur !== mon_prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cycle %0d outputs %b, required no change", cyc, mon_cur);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.v !== mon_cur) begin
            n_fail++;
            $display("FAIL event: cycle %0d outputs %b, required cycle %0d outputs %b",
                     cyc, mon_cur, mon_e.cyc, mon_e.v);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    btn_rst_n = 1'b1;
    pause_ack = 1'b0;

    // Reset state, then POR hold of 16 cycles.
    push(1, 1'b1, 1'b0, 2'd0);
    at(3);    rst = 1'b0;
    push(19, 1'b0, 1'b0, 2'd0);

    // 10-cycle glitch while running: no output change.
    at(30);   btn_rst_n = 1'b0;
    at(40);   btn_rst_n = 1'b1;

    // Acked press: pause_req at press+19, ack seen 6 cycles later, release hold after debounce.
    at(60);   btn_rst_n = 1'b0;
    push(79, 1'b0, 1'b1, 2'd0);
    at(84);   pause_ack = 1'b1;
    push(85, 1'b1, 1'b0, 2'd1);
    at(85);   pause_ack = 1'b0;
    at(100);  btn_rst_n = 1'b1;
    push(134, 1'b0, 1'b0, 2'd1);

    // Timeout: pause_req high exactly 1024 cycles.
    at(150);  btn_rst_n = 1'b0;
    push(169, 1'b0, 1'b1, 2'd1);
    at(190);  btn_rst_n = 1'b1;
    push(1193, 1'b1, 1'b0, 2'd2);
    push(1209, 1'b0, 1'b0, 2'd2);

    // Ack on the final timeout cycle: ack wins.
    at(1230); btn_rst_n = 1'b0;
    push(1249, 1'b0, 1'b1, 2'd2);
    at(1270); btn_rst_n = 1'b1;
    at(2272); pause_ack = 1'b1;
    push(2273, 1'b1, 1'b0, 2'd1);
    at(2273); pause_ack = 1'b0;
    push(2289, 1'b0, 1'b0, 2'd1);

    // rst pulse at PAUSE cycle 100, then a fresh POR hold.
    at(2300); btn_rst_n = 1'b0;
    push(2319, 1'b0, 1'b1, 2'd1);
    at(2340); btn_rst_n = 1'b1;
    at(2418); rst = 1'b1;
    push(2419, 1'b1, 1'b0, 2'd0);
    at(2419); rst = 1'b0;
    push(2435, 1'b0, 1'b0, 2'd0);

    at(2480);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: %0d events never seen, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adam_rst_seq.md
Name: adam_rst_seq

Overview:
- Board-level reset sequencer upstream of the adam SoC top. It conditions the raw active-low reset pushbutton (synchroniser plus debouncer) and holds the SoC reset for a fixed stretch after power-on or release.
- On a button press it first requests a pause and waits for pause_ack, with a timeout, before asserting the system reset.
- Its reset output drives the SoC, the bootloader and the RAM reset inputs.

Parameters:
- SYNC_STAGES, 2: synchroniser flip-flop depth (>=2).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a new button level (>=1).
- HOLD_CYCLES, 16: rst_out assertion length after the button is released (>=1).
- PAUSE_TIMEOUT, 1024: maximum cycles waiting for pause_ack; 0 means skip the pause phase.

Ports:
- clk  input  1  system clock (50 MHz domain).
- rst  input  1  synchronous active-high reset (power-on source).
- btn_rst_n  input  1  raw asynchronous pushbutton, low = pressed.
- pause_ack  input  1  SoC pause acknowledge.
- pause_req  output  1  pause request to the SoC.
- rst_out  output  1  synchronous active-high system reset to the SoC and memories.
- rst_cause  output  2  cause of the last reset: 0 POR, 1 button with ack, 2 button with timeout, 3 reserved.

Behaviour:
- Reset is decided: one clock, clk; rst is synchronous and active-high. All outputs are registered.
- rst values:
  - rst_out=1, pause_req=0, rst_cause=0.
  - State=HOLD, counters=0.
  - Synchroniser flops=1, debounced level btn_db=1.
- Synchroniser: SYNC_STAGES flops on btn_rst_n. Latency SYNC_STAGES cycles.
- Debouncer:
  - The counter increments each cycle the synced level differs from btn_db.
  - It clears to 0 on any cycle the levels are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, btn_db takes the synced level and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles never change btn_db.
- FSM (states HOLD, RUN, PAUSE):
  - HOLD: rst_out=1.
    - btn_db==0: hold count clears, stay in HOLD.
    - Otherwise: hold count increments; at HOLD_CYCLES-1 go to RUN.
    - rst_out is therefore high exactly HOLD_CYCLES cycles after rst deasserts or after btn_db rises (when rst or press preceded).
  - RUN: rst_out=0.
    - btn_db==0: go to PAUSE, pause_req<=1, timeout count <=0.
    - If PAUSE_TIMEOUT==0: go directly to HOLD, rst_out<=1, rst_cause<=1.
    - pause_ack in RUN is ignored.
  - PAUSE: rst_out=0, pause_req=1, timeout count increments.
    - pause_ack==1: go to HOLD, rst_out<=1, pause_req<=0, rst_cause<=1.
    - Else if timeout count==PAUSE_TIMEOUT-1: go to HOLD, rst_out<=1, pause_req<=0, rst_cause<=2.
    - pause_ack and timeout in the same cycle: ack wins, rst_cause=1.
    - Button release during PAUSE does not cancel the sequence.
- rst_out rises on the cycle after the accepting pause_ack.
- rst_cause changes only on entry to HOLD from PAUSE/RUN, or on rst.
- rst asserted in any state (including mid-PAUSE or mid-debounce) returns every register to its rst value on the next edge.
- Counter widths: $clog2(max(param,2))+1 bits. No counter wraps: each is compared for equality and cleared.

Decomposition:
- Shared package adam_rst_pkg:
  - rst_cause_t enum (RC_POR=0, RC_BTN=1, RC_BTN_TIMEOUT=2).
  - rst_state_t enum (HOLD, RUN, PAUSE).
- One natural sub-module, adam_debounce: synchroniser plus debouncer, parameters SYNC_STAGES and DEBOUNCE_CYCLES, ports clk, rst, in, out.
- The FSM stays in adam_rst_seq.

Test Plan:
- POR: rst high 3 cycles, btn_rst_n=1, then rst low -> rst_out stays 1 for exactly 16 cycles then 0; rst_cause=0; pause_req=0 throughout.
- Glitch: in RUN, btn_rst_n low for 10 cycles -> btn_db unchanged, pause_req and rst_out stay 0.
- Acked press:
  - Stimulus: btn_rst_n low for 40 cycles; pause_ack raised 5 cycles after pause_req rises.
  - Response: pause_req rises 1 cycle after btn_db falls (SYNC_STAGES+16 cycles after the press); rst_out=1 the cycle after the ack and pause_req drops; rst_cause=1.
  - rst_out is released 16 cycles after btn_db returns high.
- Timeout: press with pause_ack never asserted -> pause_req high exactly 1024 cycles, then rst_out=1, rst_cause=2.
- Simultaneous: pause_ack asserted on timeout cycle 1023 -> rst_cause=1.
- Reset mid-PAUSE: rst pulsed at PAUSE cycle 100 -> next edge pause_req=0, rst_out=1, rst_cause=0, then the POR hold of 16 cycles.
